// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Purpose  : Arbitrates a single-port memory bus between the instruction
//            fetch stage and the data-memory stage. Memory accesses win over
//            fetches. Each transaction holds a registered bus request until
//            the memory acknowledges it or a wait counter expires. A flush
//            turns an outstanding fetch into a dropped access that still has
//            to wait for its acknowledge before the bus is free again.
// Ports    : clk, rst (async, active-low)
//            if_req/if_addr           -> if_data/if_valid   fetch side
//            mem_req/we/addr/wdata/sel -> mem_rdata/mem_valid data side
//            flush                     branch redirect, kills a fetch
//            bus_req/we/addr/wdata/sel, bus_rdata/bus_ack   memory port
//            stall[5:0]                pipeline stall vector (pc..wb)
//            err                       one-cycle pulse on timeout abort
// Revision : 1.0  initial release
// ============================================================================
module mem_arb #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [5:0]  stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2,
        IF_DROP = 2'd3
    } state_t;

    // The counter is checked before it is incremented, so the abort happens
    // on the MAX_WAIT-th edge after the grant.
    localparam logic [7:0] c_wait_last  = 8'(MAX_WAIT - 1);
    localparam logic [5:0] c_stall_mem  = 6'b011111;
    localparam logic [5:0] c_stall_if   = 6'b000111;

    state_t      r_state,     w_state_nxt;
    logic [7:0]  r_wait_cnt,  w_wait_cnt_nxt;
    logic        r_bus_req,   w_bus_req_nxt;
    logic        r_bus_we,    w_bus_we_nxt;
    logic [31:0] r_bus_addr,  w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [3:0]  r_bus_sel,   w_bus_sel_nxt;
    logic [31:0] r_if_data,   w_if_data_nxt;
    logic        r_if_valid,  w_if_valid_nxt;
    logic [31:0] r_mem_rdata, w_mem_rdata_nxt;
    logic        r_mem_valid, w_mem_valid_nxt;
    logic        r_err,       w_err_nxt;
    logic [5:0]  w_stall;
    logic        w_timeout;

    assign w_timeout = (r_wait_cnt == c_wait_last);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 8'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_sel   <= 4'h0;
            r_if_data   <= 32'h0;
            r_if_valid  <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_mem_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_if_data   <= w_if_data_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_sel_nxt   = r_bus_sel;
        w_if_data_nxt   = r_if_data;
        w_if_valid_nxt  = 1'b0;
        w_mem_rdata_nxt = r_mem_rdata;
        w_mem_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                // bus_ack is deliberately not looked at here: a stray ack
                // (e.g. one left over from an access abandoned by reset)
                // must not complete anything.
                if (mem_req) begin
                    w_state_nxt     = MEM_ACC;
                    w_wait_cnt_nxt  = 8'd0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mem_we;
                    w_bus_addr_nxt  = mem_addr;
                    w_bus_wdata_nxt = mem_wdata;
                    w_bus_sel_nxt   = mem_sel;
                end else if (if_req && !flush) begin
                    w_state_nxt     = IF_ACC;
                    w_wait_cnt_nxt  = 8'd0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = if_addr;
                    w_bus_wdata_nxt = 32'h0;
                    w_bus_sel_nxt   = 4'b1111;
                end
            end

            IF_ACC, MEM_ACC, IF_DROP: begin
                if (bus_ack) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    // A flush arriving together with the ack still kills
                    // the fetch result.
                    if (r_state == IF_ACC && !flush) begin
                        w_if_data_nxt  = bus_rdata;
                        w_if_valid_nxt = 1'b1;
                    end
                    // Writes also capture the bus read data as-is.
                    if (r_state == MEM_ACC) begin
                        w_mem_rdata_nxt = bus_rdata;
                        w_mem_valid_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    if (r_state == IF_ACC && flush) begin
                        w_state_nxt = IF_DROP;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall vector: a pending data access freezes everything up to mem,
    // a pending fetch freezes pc/if/id. The valid pulse releases the
    // stall in the completion cycle itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = 6'b000000;
        if (mem_req && !r_mem_valid) begin
            w_stall = c_stall_mem;
        end else if (if_req && !flush && !r_if_valid) begin
            w_stall = c_stall_if;
        end
    end

    assign if_data   = r_if_data;
    assign if_valid  = r_if_valid;
    assign mem_rdata = r_mem_rdata;
    assign mem_valid = r_mem_valid;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign stall     = w_stall;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb
// Purpose  : Randomized self-checking bench for mem_arb. Random fetch and
//            data requesters plus a random-latency memory responder drive
//            the DUT; a transaction-level reference model predicts every
//            output each cycle. Ends with an asynchronous reset applied in
//            the middle of a data access followed by a stray acknowledge.
// Ports    : none (top-level bench)
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arb;

    localparam int MAX_WAIT = 4;
    localparam int N_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_data;
    logic        if_valid;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        flush = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic [5:0]  stall;
    logic        err;

    always #5 clk = ~clk;

    mem_arb #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_valid  (if_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .flush     (flush),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall     (stall),
        .err       (err)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus, for how many edges, and what was
    // captured at the grant.
    // owner: 0 = nobody, 1 = live fetch, 2 = data access, 3 = killed fetch
    // ------------------------------------------------------------------
    int          owner;
    int          age;
    logic [31:0] m_addr, m_wdata, m_if_data, m_mem_rdata;
    logic        m_we;
    logic [3:0]  m_sel;
    logic        m_if_valid, m_mem_valid, m_err;

    task automatic model_reset();
        owner = 0; age = 0;
        m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0; m_sel = 4'h0;
        m_if_data = 32'h0; m_mem_rdata = 32'h0;
        m_if_valid = 1'b0; m_mem_valid = 1'b0; m_err = 1'b0;
    endtask

    // Applies one rising edge, using the input values present at that edge.
    task automatic model_edge();
        m_if_valid = 1'b0; m_mem_valid = 1'b0; m_err = 1'b0;
        if (owner == 0) begin
            if (mem_req) begin
                owner = 2; age = 0;
                m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; m_sel = mem_sel;
            end else if (if_req && !flush) begin
                owner = 1; age = 0;
                m_addr = if_addr; m_we = 1'b0; m_sel = 4'b1111;
            end
        end else begin
            age++;
            if (bus_ack) begin
                if (owner == 1 && !flush) begin
                    m_if_valid = 1'b1; m_if_data = bus_rdata;
                end
                if (owner == 2) begin
                    m_mem_valid = 1'b1; m_mem_rdata = bus_rdata;
                end
                owner = 0;
            end else if (age >= MAX_WAIT) begin
                m_err = 1'b1; owner = 0;
            end else if (owner == 1 && flush) begin
                owner = 3;
            end
        end
    endtask

    task automatic check_outputs();
        logic [5:0] exp_stall;
        chk("bus_req",   bus_req,   owner != 0);
        if (owner != 0) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_we",   bus_we,   m_we);
            chk("bus_sel",  bus_sel,  m_sel);
            if (owner == 2) chk("bus_wdata", bus_wdata, m_wdata);
        end
        chk("if_valid",  if_valid,  m_if_valid);
        chk("if_data",   if_data,   m_if_data);
        chk("mem_valid", mem_valid, m_mem_valid);
        chk("mem_rdata", mem_rdata, m_mem_rdata);
        chk("err",       err,       m_err);
        if (mem_req && !m_mem_valid)                exp_stall = 6'b011111;
        else if (if_req && !flush && !m_if_valid)   exp_stall = 6'b000111;
        else                                        exp_stall = 6'b000000;
        chk("stall",     stall,     exp_stall);
    endtask

    task automatic check_reset_values();
        chk("rst_bus_req",   bus_req,   32'h0);
        chk("rst_bus_we",    bus_we,    32'h0);
        chk("rst_bus_addr",  bus_addr,  32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_sel",   bus_sel,   32'h0);
        chk("rst_if_data",   if_data,   32'h0);
        chk("rst_if_valid",  if_valid,  32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_mem_valid", mem_valid, 32'h0);
        chk("rst_err",       err,       32'h0);
    endtask

    // One clock: advance the model on the rising edge, compare on the
    // falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // ------------------------------------------------------------------
    // Random stimulus, applied on the falling edge after the checks
    // ------------------------------------------------------------------
    bit resp_active = 1'b0;
    int resp_delay  = 0;

    task automatic new_mem();
        logic [31:0] a;
        a = $urandom;
        mem_req   = 1'b1;
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = a & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
        mem_sel   = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_random();
        logic [31:0] a;
        // memory responder: random latency, occasionally too slow, plus
        // stray acks while the bus is idle
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (!bus_req) begin
            resp_active = 1'b0;
            if ($urandom_range(0, 9) == 0) bus_ack = 1'b1;
        end else begin
            if (!resp_active) begin
                resp_active = 1'b1;
                resp_delay  = $urandom_range(0, MAX_WAIT + 1);
            end
            if (resp_delay == 0) begin
                bus_ack = 1'b1;
                resp_active = 1'b0;
            end else begin
                resp_delay--;
            end
        end
        // data-side requester: holds its request (across aborts) until done
        if (mem_req) begin
            if (mem_valid) begin
                if ($urandom_range(0, 1) == 1) new_mem();
                else mem_req = 1'b0;
            end
        end else if ($urandom_range(0, 4) == 0) begin
            new_mem();
        end
        // fetch-side requester with occasional redirects
        flush = 1'b0;
        if (if_req && if_valid) begin
            if ($urandom_range(0, 1) == 1) if_addr = if_addr + 32'd4;
            else if_req = 1'b0;
        end else if (!if_req && $urandom_range(0, 3) == 0) begin
            a = $urandom;
            if_req  = 1'b1;
            if_addr = a & 32'hFFFF_FFFC;
        end
        if ($urandom_range(0, 9) == 0) begin
            a = $urandom;
            flush   = 1'b1;
            if_addr = a & 32'hFFFF_FFFC;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1 check_reset_values();
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();

        for (int i = 0; i < N_CYCLES; i++) begin
            drive_random();
            step();
        end

        // quiesce: any outstanding access completes or times out
        if_req = 1'b0; mem_req = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        repeat (MAX_WAIT + 2) step();

        // reset in the middle of a data write
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200;
        mem_wdata = 32'hCAFE_F00D; mem_sel = 4'b1111;
        step();
        step();
        chk("midtxn_bus_req", bus_req, 32'h1);
        #2 rst = 1'b0;
        #1 model_reset();
        check_reset_values();
        chk("rst_stall", stall, 32'h1F);
        mem_req = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b1;
        step();          // stray ack seen in IDLE must be ignored
        bus_ack = 1'b0;
        step();
        chk("stray_mem_rdata", mem_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: bus cycles allowed before a transaction is aborted (range 2..255).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  in  1  fetch request from the pc/if stage.
REQ-005 SHALL have port if_addr  in  32  fetch address.
REQ-006 SHALL have port if_data  out  32  fetched instruction, registered.
REQ-007 SHALL have port if_valid  out  1  one-cycle pulse, if_data is valid.
REQ-008 SHALL have port mem_req  in  1  data access request from the mem stage.
REQ-009 SHALL have ports mem_we in 1, mem_addr in 32, mem_wdata in 32, mem_sel in 4: write enable, address, write data, byte select.
REQ-010 SHALL have port mem_rdata  out  32  read data, registered.
REQ-011 SHALL have port mem_valid  out  1  one-cycle pulse, data access complete.
REQ-012 SHALL have port flush  in  1  branch redirect from id; kills any outstanding fetch.
REQ-013 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_sel out 4: registered single-port memory request.
REQ-014 SHALL have ports bus_rdata in 32, bus_ack in 1: memory response; ack is a one-cycle completion strobe.
REQ-015 SHALL have port stall  out  6  pipeline stall vector to ctrl (bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb).
REQ-016 SHALL have port err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 SHALL implement FSM states IDLE, IF_ACC, MEM_ACC, IF_DROP.
REQ-018 IDLE: mem_req=1 -> MEM_ACC; else if_req=1 and flush=0 -> IF_ACC; else stay IDLE. mem always wins a simultaneous request.
REQ-019 On any grant SHALL latch address/we/wdata/sel onto bus_* and set bus_req=1 on the same edge; fetch grants drive bus_we=0, bus_sel=4'b1111.
REQ-020 bus_req and all bus_* outputs SHALL stay constant until the edge that samples bus_ack=1, or a timeout; bus_req=0 the cycle after.
REQ-021 IF_ACC + bus_ack: if_data<=bus_rdata, if_valid=1 for one cycle, -> IDLE.
REQ-022 MEM_ACC + bus_ack: mem_rdata<=bus_rdata (writes load value unchanged), mem_valid=1 for one cycle, -> IDLE.
REQ-023 Latency: request sampled at edge N gives bus_req=1 after N; ack sampled at edge M gives valid=1 after M; the earliest next grant is edge M+1.
REQ-024 flush=1 in IF_ACC without ack -> IF_DROP; flush with ack on the same edge SHALL suppress if_valid, -> IDLE.
REQ-025 IF_DROP: bus_req is held; ack -> IDLE with no if_valid and if_data unchanged.
REQ-026 flush has no effect in MEM_ACC or IDLE, except that it blocks an if grant in IDLE.
REQ-027 A wait counter SHALL clear on each grant and increment each cycle in any *_ACC/IF_DROP state; when it reaches MAX_WAIT without ack: bus_req=0, err=1 for one cycle, no valid pulse, -> IDLE. The requester re-requests.
REQ-028 bus_ack sampled in IDLE SHALL be ignored.
REQ-029 stall SHALL be combinational from state and inputs:
- 6'b011111 when mem_req=1 and no mem_valid this cycle.
- else 6'b000111 when if_req=1, flush=0 and no if_valid this cycle.
- else 6'b000000.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, counter 0, bus_req/bus_we/if_valid/mem_valid/err 0, bus_addr/bus_wdata/if_data/mem_rdata 32'h0, bus_sel 4'h0.
REQ-031 Reset mid-transaction SHALL abandon it; any later bus_ack is ignored per REQ-028.
REQ-032 The first grant SHALL occur no earlier than the first rising edge after rst deasserts.

Verification
REQ-033 Fetch: if_req=1, if_addr=32'h100, ack 3 cycles after bus_req with bus_rdata=32'h3C011234 -> if_valid pulse, if_data=32'h3C011234, stall=6'b000111 during the wait.
REQ-034 Contention: if_req and mem_req rise together, mem_addr=32'h200, mem_we=1 -> mem granted first, stall=6'b011111; the fetch is granted the cycle after mem_valid.
REQ-035 Flush: flush=1 one cycle into a fetch of 32'h104 -> state IF_DROP; ack gives no if_valid; the next fetch of the new if_addr=32'h400 proceeds normally.
REQ-036 Timeout: MAX_WAIT=4, no ack -> bus_req drops after 4 cycles, err pulse, no valid pulse, re-grant follows.
REQ-037 Reset: rst=0 during MEM_ACC -> all outputs at reset values asynchronously; a stray ack after release is ignored.
